// File: rtl/fp_sqrt_pkg.sv
// Shared definitions for the sequential floating-point square-root unit:
// FSM state encodings and the fixed-latency constants.
package fp_sqrt_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ROUND = 2'd2
  } state_e;

  // Edges from the accepting edge to the edge that raises valid.
  function automatic int latency(input int man_w);
    return man_w + 3;
  endfunction

  // One root bit per CALC cycle: MAN_W+1 significant bits plus a guard bit.
  function automatic int calc_cycles(input int man_w);
    return latency(man_w) - 1;
  endfunction

endpackage

// File: rtl/fp_class.sv
// IEEE-754 operand classifier; subnormals are reported as zero so callers
// that flush denormals can treat both alike.
module fp_class #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic [EXP_W+MAN_W:0] a,
  output logic                 is_zero,
  output logic                 is_inf,
  output logic                 is_qnan,
  output logic                 is_snan,
  output logic                 is_neg
);

  logic exp_ones;
  logic exp_zero;
  logic frac_zero;

  always_comb begin
    exp_ones  = &a[EXP_W+MAN_W-1:MAN_W];
    exp_zero  = ~|a[EXP_W+MAN_W-1:MAN_W];
    frac_zero = ~|a[MAN_W-1:0];
    is_zero   = exp_zero;
    is_inf    = exp_ones & frac_zero;
    is_qnan   = exp_ones & a[MAN_W-1];
    is_snan   = exp_ones & ~frac_zero & ~a[MAN_W-1];
    is_neg    = a[EXP_W+MAN_W];
  end

endmodule

// File: rtl/fp_sqrt_seq.sv
// Sequential IEEE-754 square root: radix-2 restoring recurrence, one root bit
// per cycle, round-to-nearest-even, fixed latency for every operand class.
module fp_sqrt_seq
  import fp_sqrt_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] a,
  output logic                 busy,
  output logic                 valid,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 flag_nv,
  output logic                 flag_nx
);

  // Handshake: start is taken on any edge where busy=0 (including the cycle
  // valid is high); busy then stays high until valid pulses for one cycle,
  // and result/flags hold their value until the next valid.
  localparam int W  = EXP_W + MAN_W + 1;
  localparam int RW = 2 * MAN_W + 4;
  localparam int DW = MAN_W + 4;
  localparam int CW = $clog2(MAN_W + 2);
  localparam logic [CW-1:0]  CNT_LAST = CW'(calc_cycles(MAN_W) - 1);
  localparam logic [EXP_W:0] BIAS     = {2'b00, {(EXP_W-1){1'b1}}};
  localparam logic [W-1:0]   QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0]   PINF     = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  state_e state, state_nxt;
  logic accept, step_en, finish;

  logic c_zero, c_inf, c_qnan, c_snan, c_neg;
  logic           spec_d, spec_nv_d;
  logic [W-1:0]   spec_res_d;
  logic [EXP_W:0] exp_sum;
  logic [RW-1:0]  rad_init;

  logic [CW-1:0]    cnt;
  logic [RW-1:0]    rad;
  logic [DW-1:0]    rem, root;
  logic [DW-1:0]    rem_sh, trial;
  logic             ge;
  logic [EXP_W-1:0] res_exp;
  logic             spec_q, spec_nv;
  logic [W-1:0]     spec_res;
  logic             guard, sticky, rnd_up;
  logic [MAN_W-1:0] mant;
  logic             unused_bits;

  fp_class #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class (
    .a       (a),
    .is_zero (c_zero),
    .is_inf  (c_inf),
    .is_qnan (c_qnan),
    .is_snan (c_snan),
    .is_neg  (c_neg)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (cnt == CNT_LAST) state_nxt = S_ROUND;
      S_ROUND: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    accept  = (state == S_IDLE) && start;
    step_en = (state == S_CALC);
    finish  = (state == S_ROUND);
  end

  // NaN outranks sign; a flushed subnormal keeps its sign like a true zero.
  always_comb begin
    spec_d     = 1'b1;
    spec_nv_d  = 1'b0;
    spec_res_d = QNAN;
    if (c_qnan || c_snan)  spec_nv_d  = c_snan;
    else if (c_zero)       spec_res_d = {a[W-1], {(W-1){1'b0}}};
    else if (c_neg)        spec_nv_d  = 1'b1;
    else if (c_inf)        spec_res_d = PINF;
    else                   spec_d     = 1'b0;
  end

  // Even biased exponent means odd unbiased exponent: pre-shift the radicand.
  always_comb begin
    exp_sum  = {1'b0, a[W-2:MAN_W]} + BIAS;
    rad_init = a[MAN_W] ? {1'b0, 1'b1, a[MAN_W-1:0], {(MAN_W+2){1'b0}}}
                        : {1'b1, a[MAN_W-1:0], {(MAN_W+3){1'b0}}};
  end

  always_comb begin
    rem_sh = {rem[MAN_W+1:0], rad[RW-1 -: 2]};
    trial  = {root[DW-3:0], 2'b01};
    ge     = (rem_sh >= trial);
    guard  = root[0];
    sticky = |rem;
    rnd_up = guard & (sticky | root[1]);
    mant   = root[MAN_W:1] + {{(MAN_W-1){1'b0}}, rnd_up};
  end

  // The root never grows past MAN_W+2 bits and the sum LSB is halved away.
  assign unused_bits = ^{root[DW-1:DW-2], exp_sum[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      res_exp  <= '0;
      spec_q   <= 1'b0;
      spec_nv  <= 1'b0;
      spec_res <= '0;
      valid    <= 1'b0;
      result   <= '0;
      flag_nv  <= 1'b0;
      flag_nx  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        cnt      <= '0;
        rad      <= rad_init;
        rem      <= '0;
        root     <= '0;
        res_exp  <= exp_sum[EXP_W:1];
        spec_q   <= spec_d;
        spec_nv  <= spec_nv_d;
        spec_res <= spec_res_d;
      end else if (step_en) begin
        cnt  <= cnt + 1'b1;
        rad  <= rad << 2;
        rem  <= ge ? (rem_sh - trial) : rem_sh;
        root <= {root[DW-2:0], ge};
      end
      if (finish) begin
        valid <= 1'b1;
        if (spec_q) begin
          result  <= spec_res;
          flag_nv <= spec_nv;
          flag_nx <= 1'b0;
        end else begin
          result  <= {1'b0, res_exp, mant};
          flag_nv <= 1'b0;
          flag_nx <= guard | sticky;
        end
      end
    end
  end

endmodule
